// File: rtl/ppu_pkg.sv
// Shared types and constants for the post-processing unit.
package ppu_pkg;

    localparam int         PPU_LANES  = 4;
    localparam logic [7:0] PPU_PAD    = 8'h80;
    localparam logic [7:0] PPU_ZP_XOR = 8'h80;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } ppu_state_e;

endpackage : ppu_pkg

// File: rtl/ppu_requant.sv
// Combinational requantiser: optional ReLU, rounding arithmetic shift,
// int8 saturation and re-bias to offset-128 uint8.
module ppu_requant
    import ppu_pkg::*;
#(
    parameter int DATA_BITS  = 32,
    parameter int SHIFT_BITS = 5
) (
    input  logic [DATA_BITS-1:0]  psum,
    input  logic [SHIFT_BITS-1:0] scale,
    input  logic                  relu,
    output logic [7:0]            byte_out
);

    // Two guard bits keep the rounding add of a max-positive psum from overflowing.
    localparam int XW = DATA_BITS + 2;
    localparam logic signed [XW-1:0] SAT_MAX = XW'(127);
    localparam logic signed [XW-1:0] SAT_MIN = -XW'(128);

    logic signed [XW-1:0] x;
    logic signed [XW-1:0] y;
    logic        [7:0]    sat;

    always_comb begin
        x = {{2{psum[DATA_BITS-1]}}, psum};
        if (relu && x[XW-1]) begin
            x = '0;
        end
        if (scale != '0) begin
            x = x + (XW'(1) << (scale - 1'b1));
        end
        y = x >>> scale;
        if (y > SAT_MAX) begin
            sat = 8'h7F;
        end else if (y < SAT_MIN) begin
            sat = 8'h80;
        end else begin
            sat = y[7:0];
        end
        byte_out = sat ^ PPU_ZP_XOR;
    end

endmodule : ppu_requant

// File: rtl/ppu.sv
// Post-processing unit: requantises PE partial sums and packs four
// offset-128 bytes per word for write-back as next-layer ifmap.
module ppu
    import ppu_pkg::*;
#(
    parameter int DATA_BITS  = 32,
    parameter int SHIFT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [SHIFT_BITS-1:0] cfg_scale,
    input  logic                  cfg_relu,
    input  logic [DATA_BITS-1:0]  psum_data,
    input  logic                  psum_valid,
    output logic                  psum_ready,
    input  logic                  flush,
    output logic [DATA_BITS-1:0]  ofmap_data,
    output logic                  ofmap_valid,
    input  logic                  ofmap_ready,
    output logic [15:0]           word_cnt
);

    localparam logic [DATA_BITS-1:0] PACK_IDLE = {PPU_LANES{PPU_PAD}};

    ppu_state_e            state_q, state_d;
    logic [1:0]            lane_q, lane_d;
    logic [DATA_BITS-1:0]  pack_q, pack_d;
    logic [SHIFT_BITS-1:0] scale_q;
    logic                  relu_q;
    logic [15:0]           word_cnt_q;
    logic [7:0]            req_byte;
    logic                  psum_fire;

    ppu_requant #(
        .DATA_BITS  (DATA_BITS),
        .SHIFT_BITS (SHIFT_BITS)
    ) u_requant (
        .psum     (psum_data),
        .scale    (scale_q),
        .relu     (relu_q),
        .byte_out (req_byte)
    );

    assign psum_fire   = psum_valid && (state_q == ST_COLLECT);
    assign psum_ready  = (state_q == ST_COLLECT);
    assign ofmap_valid = (state_q == ST_DRAIN);
    assign ofmap_data  = pack_q;
    assign word_cnt    = word_cnt_q;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        pack_d  = pack_q;
        unique case (state_q)
            ST_COLLECT: begin
                if (psum_fire) begin
                    pack_d[{lane_q, 3'b000} +: 8] = req_byte;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        state_d = ST_DRAIN;
                    end
                end
                // The same-cycle element is stored before the flush is judged.
                if (flush && (psum_fire || lane_q != 2'd0)) begin
                    state_d = ST_DRAIN;
                    lane_d  = 2'd0;
                end
            end
            ST_DRAIN: begin
                if (ofmap_ready) begin
                    state_d = ST_COLLECT;
                    pack_d  = PACK_IDLE;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COLLECT;
            lane_q     <= 2'd0;
            pack_q     <= PACK_IDLE;
            scale_q    <= '0;
            relu_q     <= 1'b0;
            word_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            // Config only changes on a word boundary so one word never mixes scales.
            if (cfg_valid && state_q == ST_COLLECT && lane_q == 2'd0) begin
                scale_q <= cfg_scale;
                relu_q  <= cfg_relu;
            end
            if (state_q == ST_DRAIN && ofmap_ready) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

endmodule : ppu

// File: doc/ppu.md
# ppu

Post-processing unit directly downstream of the PE array opsum port. Consumes 32-bit signed partial sums over a valid/ready handshake and applies optional ReLU, a rounding arithmetic right shift and saturation to int8. It re-biases each result to the offset-128 uint8 format that the PE ifmap path expects, then packs four results per 32-bit word for write-back to the global buffer as next-layer ifmap.

## Interface
- `DATA_BITS`, 32: psum input and packed output width.
- `SHIFT_BITS`, 5: width of the scale (shift amount) field.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: load `cfg_scale`/`cfg_relu`. Honoured only when state is COLLECT and `lane_cnt`==0; otherwise ignored.
- `cfg_scale` in `SHIFT_BITS`: right-shift amount, 0..31.
- `cfg_relu` in 1: 1 = clamp negative psums to 0 before shifting.
- `psum_data` in `DATA_BITS`: signed partial sum, connected to PE `opsum`.
- `psum_valid` in 1: connected to PE `opsum_valid`.
- `psum_ready` out 1: connected to PE `opsum_ready`.
- `flush` in 1: single-cycle pulse that emits a partially filled word.
- `ofmap_data` out `DATA_BITS`: packed word; element 0 in bits [7:0].
- `ofmap_valid` out 1: output word valid.
- `ofmap_ready` in 1: downstream accept.
- `word_cnt` out 16: count of words emitted since reset; wraps at 65535→0.

## Operation
- States: COLLECT and DRAIN.
  - `psum_ready` = (state==COLLECT).
  - `ofmap_valid` = (state==DRAIN).
- Psum handshake: `psum_valid && psum_ready`.
- Per accepted psum x, all math signed 34-bit:
  - If `cfg_relu` and x<0, x=0.
  - If scale>0, x += 1<<(scale-1) (round half up).
  - y = x >>> scale.
  - Saturate y to [-128,127].
  - byte = y[7:0] ^ 8'h80.
- Store byte in lane `lane_cnt` of the pack register (bits [8k+7:8k]), then increment `lane_cnt` (2 bits).
  - On the 4th accepted byte (`lane_cnt`==3), go to DRAIN and reset `lane_cnt` to 0.
- Flush in COLLECT with `lane_cnt`>0 goes to DRAIN. Unfilled lanes are padded with 8'h80 (encodes int8 zero).
  - Flush with `lane_cnt`==0: ignored.
  - Flush in DRAIN: ignored.
- Flush in the same cycle as a psum handshake: the element is stored first, then the flush applies.
  - If that element was the 4th, this is a normal drain; no extra word is emitted.
- DRAIN: `ofmap_data` is held stable until `ofmap_ready`. On that handshake:
  - go to COLLECT,
  - refill the pack register with 8'h80 in all lanes,
  - increment `word_cnt`.
- Config registers (scale, relu) persist across words and are cleared only by reset.

## Timing
- Reset values:
  - state=COLLECT, `lane_cnt`=0, pack register=32'h80808080, scale=0, relu=0, `word_cnt`=0.
  - Outputs: `psum_ready`=1, `ofmap_valid`=0, `ofmap_data`=32'h80808080.
- Latency: `ofmap_valid` rises the cycle after the 4th psum handshake, or the cycle after the qualifying flush.
- Throughput: 4 psums plus at least 1 drain cycle per word. `psum_ready` is low throughout DRAIN; no input overlap.
- Backpressure: `ofmap_valid` stays high with stable data while `ofmap_ready`=0.
- `psum_ready` rises the cycle after the output handshake.
- `cfg_valid` takes effect on the psum accepted in the following cycle.
- Reset asserted mid-word or mid-DRAIN: the next cycle shows reset values. The partial word is discarded and not emitted.

## Structure
- Shared package `ppu_pkg`:
  - `PPU_LANES`=4,
  - `PPU_PAD`=8'h80,
  - `PPU_ZP_XOR`=8'h80,
  - state enum `ppu_state_e`.
- One combinational sub-module `ppu_requant` (psum, scale, relu → byte).
  - Instantiated once.
  - Reusable by a future multi-lane PPU.

## Test plan
- Scale=0, relu=0; psums 1,2,3,4 → one word 32'h84838281, `ofmap_valid` one cycle after the 4th handshake, `word_cnt`=1.
- Scale=1, relu=1; psums -1000,1000,255,3 → 32'h82FFFF80 (checks ReLU, saturation, rounding 255→128→127, 3→2).
- Scale=1, relu=0; psums -3,-5,300,-300 → bytes 7F,7E,FF,00 → 32'h00FF7E7F.
- Scale=0; psums 10,-10, then flush → 32'h8080768A. A second flush with no data produces no word.
- Hold `ofmap_ready`=0 for 5 cycles while driving `psum_valid`=1 → `psum_ready`=0 and `ofmap_data` stable for all 5 cycles. No psum is consumed until one cycle after `ofmap_ready`.
- Reset during DRAIN → next cycle `ofmap_valid`=0, `psum_ready`=1, `word_cnt`=0. `cfg_valid` with `lane_cnt`=2 → old scale still applied.
